// File: rtl/seq_arith_pkg.sv
// Shared definitions for the sequential arithmetic units (divider, multiplier).
// Holds the FSM state enumeration and the default operand width.
package seq_arith_pkg;

  // Default operand/result width in bits.
  localparam int unsigned DEF_W = 8;

  // Sequencer states shared by the iterative arithmetic blocks.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step (purely combinational).
// Ports:
//   rem_in  - current (N+1)-bit partial remainder
//   dbit    - next dividend bit, MSB first
//   bmag    - divisor magnitude |b|
//   rem_out - partial remainder after this step
//   qbit    - quotient bit produced by this step
module div_step
  import seq_arith_pkg::*;
#(
  parameter int unsigned N = DEF_W
) (
  input  logic [N:0]   rem_in,
  input  logic         dbit,
  input  logic [N-1:0] bmag,
  output logic [N:0]   rem_out,
  output logic         qbit
);

  logic [N+1:0] shifted;
  logic [N+1:0] diff;

  // Shift in the dividend bit, trial-subtract |b|, restore when negative.
  always_comb begin
    shifted = {rem_in, dbit};
    diff    = shifted - {2'b00, bmag};
    qbit    = ~diff[N+1];
    rem_out = qbit ? diff[N:0] : shifted[N:0];
  end

endmodule

// File: rtl/seq_div.sv
// Sequential signed divider: N restoring steps, one per cycle, truncating
// toward zero with the remainder taking the dividend's sign.
// Ports:
//   clk, rst       - clock, asynchronous active-low reset
//   start, a, b    - request pulse with signed dividend/divisor (sampled in IDLE)
//   q, r           - registered signed quotient / remainder
//   dz, ovf        - divide-by-zero and -2^(N-1)/-1 overflow flags
//   valid, busy    - one-cycle result pulse, operation-in-progress flag
module seq_div
  import seq_arith_pkg::*;
#(
  parameter int unsigned N = DEF_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] q,
  output logic [N-1:0] r,
  output logic         valid,
  output logic         busy,
  output logic         dz,
  output logic         ovf
);

  localparam int unsigned CW    = $clog2(N);
  localparam logic [N-1:0] MIN_V = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] ONE_V = N'(1);

  state_t state, state_n;

  logic [CW-1:0] cnt;
  logic [N-1:0]  a_cap;
  logic [N-1:0]  dvd;
  logic [N-1:0]  bmag;
  logic [N-1:0]  quo;
  logic [N:0]    rem;
  logic [N:0]    rem_nx;
  logic          qbit;
  logic          sa, sb;

  div_step #(.N(N)) u_step (
    .rem_in (rem),
    .dbit   (dvd[N-1]),
    .bmag   (bmag),
    .rem_out(rem_nx),
    .qbit   (qbit)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = CALC;
      CALC:    if (cnt == CW'(N - 1)) state_n = FIX;
      FIX:     state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Datapath and registered outputs. busy/valid are registered from the
  // state, so they trail it by one cycle: valid lands N+2 edges after start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      a_cap <= '0;
      dvd   <= '0;
      bmag  <= '0;
      quo   <= '0;
      rem   <= '0;
      sa    <= 1'b0;
      sb    <= 1'b0;
      q     <= '0;
      r     <= '0;
      dz    <= 1'b0;
      ovf   <= 1'b0;
      valid <= 1'b0;
      busy  <= 1'b0;
    end else begin
      valid <= (state == DONE);
      busy  <= (state == CALC) || (state == FIX);
      case (state)
        IDLE: begin
          if (start) begin
            a_cap <= a;
            sa    <= a[N-1];
            sb    <= b[N-1];
            // Unsigned magnitude keeps 2^(N-1) intact for the most negative value.
            dvd   <= a[N-1] ? N'(-a) : a;
            bmag  <= b[N-1] ? N'(-b) : b;
            cnt   <= '0;
            rem   <= '0;
            quo   <= '0;
          end
        end
        CALC: begin
          rem <= rem_nx;
          quo <= {quo[N-2:0], qbit};
          dvd <= {dvd[N-2:0], 1'b0};
          cnt <= cnt + CW'(1);
        end
        FIX: begin
          if (bmag == '0) begin
            q   <= '1;
            r   <= a_cap;
            dz  <= 1'b1;
            ovf <= 1'b0;
          end else begin
            // Overflow case needs no special datapath: 2^(N-1) wraps to MIN_V.
            q   <= (sa ^ sb) ? N'(-quo) : quo;
            r   <= sa ? N'(-rem[N-1:0]) : rem[N-1:0];
            dz  <= 1'b0;
            ovf <= sa & sb & (a_cap == MIN_V) & (bmag == ONE_V);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div (N=8): cycle-level reference model plus
// directed operations with hand-computed results.
module tb_seq_div;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic [N-1:0] q, r;
  logic         valid, busy, dz, ovf;

  int ncmp = 0;
  int nerr = 0;
  bit chk_en = 1'b0;

  seq_div #(.N(N)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .q    (q),
    .r    (r),
    .valid(valid),
    .busy (busy),
    .dz   (dz),
    .ovf  (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: truncating signed division with the two special cases.
  task automatic ref_div(input int ai, input int bi, output int eq, output int er,
                         output int edz, output int eovf);
    edz = 0; eovf = 0;
    if (bi == 0) begin
      eq = -1; er = ai; edz = 1;
    end else if (ai == -128 && bi == -1) begin
      eq = -128; er = 0; eovf = 1;
    end else begin
      eq = ai / bi; er = ai % bi;
    end
  endtask

  // Cycle model: start accepted at edge acc; q/r load at acc+N+1, valid at
  // acc+N+2, busy over acc+1..acc+N+1, next accept from acc+N+3.
  int cyc = 0, acc = -1;
  int mq = 0, mr = 0, mdz = 0, movf = 0, mv = 0, mb = 0;
  int pq = 0, pr = 0, pdz = 0, povf = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc = 0; acc = -1;
      mq = 0; mr = 0; mdz = 0; movf = 0; mv = 0; mb = 0;
    end else begin
      cyc++;
      mv = (acc >= 0 && cyc == acc + N + 2) ? 1 : 0;
      mb = (acc >= 0 && cyc >= acc + 1 && cyc <= acc + N + 1) ? 1 : 0;
      if (acc >= 0 && cyc == acc + N + 1) begin
        mq = pq; mr = pr; mdz = pdz; movf = povf;
      end
      if (start && (acc < 0 || cyc >= acc + N + 3)) begin
        acc = cyc;
        ref_div($signed(a), $signed(b), pq, pr, pdz, povf);
      end
    end
  end

  // Continuous compare against the model.
  always @(negedge clk) begin
    #1;
    if (chk_en) begin
      chk("valid", {31'b0, valid}, mv);
      chk("busy", {31'b0, busy}, mb);
      chk("q", $signed(q), mq);
      chk("r", $signed(r), mr);
      chk("dz", {31'b0, dz}, mdz);
      chk("ovf", {31'b0, ovf}, movf);
    end
  end

  // One division with literal expectations; now=1 drives start without
  // waiting a cycle (back-to-back), disturb=1 scrambles inputs and re-pulses start.
  task automatic do_op(input int ai, input int bi, input int eq, input int er,
                       input int edz, input int eovf, input bit now, input bit disturb);
    int  bc, lat;
    bit  found;
    if (!now) @(negedge clk);
    a = 8'(ai); b = 8'(bi); start = 1'b1;
    found = 1'b0; bc = 0; lat = 0;
    for (int i = 1; i <= 20 && !found; i++) begin
      @(negedge clk);
      if (i == 1) begin
        start = 1'b0;
        if (disturb) begin a = 8'($urandom); b = 8'($urandom); end
      end
      if (disturb && i == 4) begin start = 1'b1; a = 8'(-3); b = 8'(2); end
      if (disturb && i == 5) start = 1'b0;
      #2;
      if (busy) bc++;
      if (valid) begin found = 1'b1; lat = i - 1; end
    end
    if (!found) begin
      ncmp++; nerr++;
      $display("FAIL valid_timeout: got none expected valid for %0d/%0d", ai, bi);
    end else begin
      chk("latency", lat, 10);
      chk("busy_cycles", bc, 9);
      chk("op_q", $signed(q), eq);
      chk("op_r", $signed(r), er);
      chk("op_dz", {31'b0, dz}, edz);
      chk("op_ovf", {31'b0, ovf}, eovf);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ai, bi, eq, er, edz, eovf, nv;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    #2;
    chk("reset_q", $signed(q), 0);
    chk("reset_valid", {31'b0, valid}, 0);
    chk("reset_busy", {31'b0, busy}, 0);
    @(negedge clk);
    rst = 1'b1;

    do_op(100, 7, 14, 2, 0, 0, 1'b0, 1'b0);
    do_op(-100, 7, -14, -2, 0, 0, 1'b0, 1'b0);
    do_op(100, -7, -14, 2, 0, 0, 1'b0, 1'b0);
    do_op(-100, -7, 14, -2, 0, 0, 1'b0, 1'b0);
    do_op(-128, -1, -128, 0, 0, 1, 1'b0, 1'b0);
    do_op(5, 0, -1, 5, 1, 0, 1'b0, 1'b0);
    do_op(-128, 1, -128, 0, 0, 0, 1'b0, 1'b0);
    do_op(7, 100, 0, 7, 0, 0, 1'b0, 1'b0);
    do_op(-128, 0, -1, -128, 1, 0, 1'b0, 1'b0);
    do_op(100, 7, 14, 2, 0, 0, 1'b0, 1'b1);

    // Back-to-back.
    do_op(127, 1, 127, 0, 0, 0, 1'b0, 1'b0);
    do_op(-1, 127, 0, -1, 0, 0, 1'b1, 1'b0);

    // Abort during the fourth CALC cycle.
    @(negedge clk);
    a = 8'(100); b = 8'(7); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #2;
    chk("abort_q", $signed(q), 0);
    chk("abort_r", $signed(r), 0);
    chk("abort_busy", {31'b0, busy}, 0);
    chk("abort_valid", {31'b0, valid}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    nv = 0;
    repeat (15) begin
      @(negedge clk); #2;
      if (valid) nv++;
    end
    chk("abort_no_valid", nv, 0);
    do_op(-100, 7, -14, -2, 0, 0, 1'b0, 1'b0);

    // Random signed sweep.
    for (int k = 0; k < 20; k++) begin
      ai = int'($urandom_range(0, 255)) - 128;
      bi = int'($urandom_range(0, 255)) - 128;
      ref_div(ai, bi, eq, er, edz, eovf);
      do_op(ai, bi, eq, er, edz, eovf, 1'b0, 1'b0);
    end

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
